micro_sequencer: RTL

- Parametrised microprogram sequencer, the successor to the cascaded 4-bit sequencer slices in the CPU core.
- Single block of configurable address width and stack depth.
- Adds an Am2910-class 16-instruction set, an internal loop counter, on-chip condition select/polarity, and case OR-in on every address source.
- Drives the microcode ROM address; the microcode pipeline register and the map ROM sit outside it.

---
 rtl/micro_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Parametrised Am2910-class microprogram sequencer: 16-opcode next-address
// selection, return stack, loop counter and condition select/polarity.
module micro_sequencer #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 5,
    parameter int NUM_COND    = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  instr,
    input  logic [ADDR_W-1:0]           d_in,
    input  logic [ADDR_W-1:0]           map_in,
    input  logic [ADDR_W-1:0]           or_in,
    input  logic                        ccen,
    input  logic [$clog2(NUM_COND)-1:0] cond_sel,
    input  logic                        cond_pol,
    input  logic [NUM_COND-1:0]         cond_in,
    input  logic                        hold,
    output logic [ADDR_W-1:0]           y,
    output logic                        map_oe,
    output logic                        stack_full,
    output logic                        stack_ovf,
    output logic                        stack_unf
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STACK_DEPTH - 1);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,  OP_CJS  = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,  OP_JSRP = 4'd5,  OP_CJV  = 4'd6,  OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,  OP_RPCT = 4'd9,  OP_CRTN = 4'd10, OP_CJPP = 4'd11,
        OP_LDCT = 4'd12, OP_LOOP = 4'd13, OP_CONT = 4'd14, OP_TWB  = 4'd15
    } op_t;

    typedef enum logic [2:0] {
        SRC_PC, SRC_D, SRC_TOP, SRC_MAP, SRC_CNT, SRC_ZERO
    } src_t;

    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]   sp;

    op_t               op;
    src_t              src;
    logic              cond_bit;
    logic              pass;
    logic              cnt_nz;
    logic              empty;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] src_val;
    logic              push;
    logic              pop;
    logic              clear_sp;
    logic              load_cnt;
    logic              dec_cnt;
    logic              top_use;

    assign op         = op_t'(instr);
    assign cnt_nz     = (cnt != '0);
    assign empty      = (sp == '0);
    assign stack_full = (sp == SP_FULL);
    assign top        = empty ? '0 : stack[sp - 1'b1];

    always_comb begin
        cond_bit = 1'b0;
        if (int'(cond_sel) < NUM_COND)
            cond_bit = cond_in[cond_sel];
        pass = ~ccen | (cond_bit ^ cond_pol);
    end

    // Opcode decode: address source plus the single stack/counter action.
    always_comb begin
        src      = SRC_PC;
        push     = 1'b0;
        pop      = 1'b0;
        clear_sp = 1'b0;
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        map_oe   = 1'b0;
        unique case (op)
            OP_JZ: begin
                src      = SRC_ZERO;
                clear_sp = 1'b1;
            end
            OP_CJS: begin
                src  = pass ? SRC_D : SRC_PC;
                push = pass;
            end
            OP_JMAP: begin
                src    = SRC_MAP;
                map_oe = 1'b1;
            end
            OP_CJP, OP_CJV: src = pass ? SRC_D : SRC_PC;
            OP_PUSH: begin
                push     = 1'b1;
                load_cnt = pass;
            end
            OP_JSRP: begin
                src  = pass ? SRC_D : SRC_CNT;
                push = 1'b1;
            end
            OP_JRP: src = pass ? SRC_D : SRC_CNT;
            OP_RFCT: begin
                src     = cnt_nz ? SRC_TOP : SRC_PC;
                dec_cnt = cnt_nz;
                pop     = ~cnt_nz;
            end
            OP_RPCT: begin
                src     = cnt_nz ? SRC_D : SRC_PC;
                dec_cnt = cnt_nz;
            end
            OP_CRTN: begin
                src = pass ? SRC_TOP : SRC_PC;
                pop = pass;
            end
            OP_CJPP: begin
                src = pass ? SRC_D : SRC_PC;
                pop = pass;
            end
            OP_LDCT: load_cnt = 1'b1;
            OP_LOOP: begin
                src = pass ? SRC_PC : SRC_TOP;
                pop = pass;
            end
            OP_CONT: src = SRC_PC;
            OP_TWB: begin
                if (pass) begin
                    pop = 1'b1;
                end else if (cnt_nz) begin
                    src     = SRC_TOP;
                    dec_cnt = 1'b1;
                end else begin
                    src = SRC_D;
                    pop = 1'b1;
                end
            end
            default: src = SRC_PC;
        endcase
        top_use = (src == SRC_TOP);
    end

    always_comb begin
        unique case (src)
            SRC_PC:   src_val = upc;
            SRC_D:    src_val = d_in;
            SRC_TOP:  src_val = top;
            SRC_MAP:  src_val = map_in;
            SRC_CNT:  src_val = cnt;
            default:  src_val = '0;
        endcase
        y = reset ? '0 : (src_val | or_in);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc       <= '0;
            cnt       <= '0;
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!hold) begin
            upc <= y + 1'b1;
            if (load_cnt)
                cnt <= d_in;
            else if (dec_cnt)
                cnt <= cnt - 1'b1;
            if (clear_sp)
                sp <= '0;
            else if (push && !stack_full)
                sp <= sp + 1'b1;
            else if (pop && !empty)
                sp <= sp - 1'b1;
            if (push && stack_full)
                stack_ovf <= 1'b1;
            if ((pop || top_use) && empty)
                stack_unf <= 1'b1;
        end
    end

    // Stack storage carries no reset; sp alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && !hold && push)
            stack[stack_full ? SP_LAST : sp] <= upc;
    end

endmodule
